serial_frame_rx: RTL and testbench

- Parametrised successor to our single-byte serial receiver with parity check.
- Samples one serial bit per CLKOUT rising edge and assembles frames: start, DATA_W data bits LSB-first, optional parity bit, optional stop bit.
- Checks each frame and queues good frames in a small FIFO.
- Presents queued frames on a valid/ready interface to downstream logic.

---
 rtl/serial_rx_pkg.sv | 20 ++
 rtl/serial_rx_fifo.sv | 47 ++++
 rtl/serial_frame_rx.sv | 150 +++++++++++++++
 tb/tb_serial_frame_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // ones_odd is the XOR of data and parity bits.
  function automatic logic parity_bad(input int mode, input logic ones_odd);
    return (mode == PAR_ODD) ? ~ones_odd : ones_odd;
  endfunction

endpackage

// File: rtl/serial_rx_fifo.sv
// Small frame FIFO: array storage, combinational head read, DATA forced to 0 while empty.
module serial_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;

  // The caller only pops when non-empty and only pushes when not full or popping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start, LSB-first data, optional parity/stop, FIFO'd output.
// Optional error/overflow counters when SERIAL_FRAME_RX_STATS_EN is defined.
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_CHECK  = 1,
  parameter int DEPTH       = 4
) (
  input  logic              CLKOUT,
  input  logic              RST,
  input  logic              Rx,
  output logic [DATA_W-1:0] DATA,
  output logic              VALID,
  input  logic              READY,
  output logic              DONE,
  output logic              Rx_error,
  output logic              FRAME_ERR,
  output logic              OVERFLOW
`ifdef SERIAL_FRAME_RX_STATS_EN
  ,
  output logic [15:0]       ERR_CNT,
  output logic [15:0]       OVF_CNT
`endif
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              xor_q, par_err_q;
  logic              done_q, perr_q, ferr_q, ovf_q;

  logic [DATA_W-1:0] data_now;
  logic              par_bad_now, commit, c_par_err, c_frm_err, good;
  logic              fifo_full, fifo_empty, pop, push;

  // Commit is decided on the edge sampling the final bit, so the push is combinational.
  always_comb begin
    data_now = shift_q;
    if (state_q == S_DATA) data_now[cnt_q] = Rx;
    par_bad_now = parity_bad(PARITY_MODE, xor_q ^ Rx);
    commit    = 1'b0;
    c_par_err = par_err_q;
    c_frm_err = 1'b0;
    case (state_q)
      S_DATA:   commit = (cnt_q == LAST_BIT) && (PARITY_MODE == PAR_NONE) && (STOP_CHECK == 0);
      S_PARITY: begin
        commit    = (STOP_CHECK == 0);
        c_par_err = par_bad_now;
      end
      S_STOP:   begin
        commit    = 1'b1;
        c_frm_err = ~Rx;
      end
      default:  ;
    endcase
    good = commit && !c_par_err && !c_frm_err;
    pop  = !fifo_empty && READY;
    push = good && (!fifo_full || pop);
  end

  always_ff @(posedge CLKOUT or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      xor_q     <= 1'b0;
      par_err_q <= 1'b0;
      done_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= push;
      perr_q <= commit && c_par_err;
      ferr_q <= commit && c_frm_err;
      ovf_q  <= good && !push;
      case (state_q)
        S_IDLE: begin
          if (!Rx) begin
            state_q   <= S_DATA;
            cnt_q     <= '0;
            shift_q   <= '0;
            xor_q     <= 1'b0;
            par_err_q <= 1'b0;
          end
        end
        S_DATA: begin
          shift_q <= data_now;
          xor_q   <= xor_q ^ Rx;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            if (PARITY_MODE != PAR_NONE) state_q <= S_PARITY;
            else if (STOP_CHECK != 0)    state_q <= S_STOP;
            else                         state_q <= S_IDLE;
          end
        end
        S_PARITY: begin
          par_err_q <= par_bad_now;
          state_q   <= (STOP_CHECK != 0) ? S_STOP : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  serial_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (CLKOUT),
    .rst     (RST),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (data_now),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .rdata_o (DATA)
  );

  assign VALID     = !fifo_empty;
  assign DONE      = done_q;
  assign Rx_error  = perr_q;
  assign FRAME_ERR = ferr_q;
  assign OVERFLOW  = ovf_q;

`ifdef SERIAL_FRAME_RX_STATS_EN
  logic [15:0] err_cnt_q, ovf_cnt_q;

  always_ff @(posedge CLKOUT or posedge RST) begin
    if (RST) begin
      err_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else begin
      if (commit && (c_par_err || c_frm_err) && (err_cnt_q != 16'hFFFF))
        err_cnt_q <= err_cnt_q + 16'd1;
      if (good && !push && (ovf_cnt_q != 16'hFFFF))
        ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end

  assign ERR_CNT = err_cnt_q;
  assign OVF_CNT = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed table, corner sequences, random frames vs a queue model.
module tb_serial_frame_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rx, ready;
  logic [7:0] data;
  logic       valid, done, perr, ferr, ovf;
  logic        rx12, ready12;
  logic [11:0] data12;
  logic        valid12, done12, perr12, ferr12, ovf12;
`ifdef SERIAL_FRAME_RX_STATS_EN
  logic [15:0] err_cnt, ovf_cnt, err_cnt12, ovf_cnt12;
`endif

  serial_frame_rx dut (
    .CLKOUT(clk), .RST(rst), .Rx(rx), .DATA(data), .VALID(valid), .READY(ready),
    .DONE(done), .Rx_error(perr), .FRAME_ERR(ferr), .OVERFLOW(ovf)
`ifdef SERIAL_FRAME_RX_STATS_EN
    , .ERR_CNT(err_cnt), .OVF_CNT(ovf_cnt)
`endif
  );

  serial_frame_rx #(.DATA_W(12), .PARITY_MODE(2), .STOP_CHECK(0), .DEPTH(4)) dut12 (
    .CLKOUT(clk), .RST(rst), .Rx(rx12), .DATA(data12), .VALID(valid12), .READY(ready12),
    .DONE(done12), .Rx_error(perr12), .FRAME_ERR(ferr12), .OVERFLOW(ovf12)
`ifdef SERIAL_FRAME_RX_STATS_EN
    , .ERR_CNT(err_cnt12), .OVF_CNT(ovf_cnt12)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] model_q[$];
  int model_err = 0;
  int model_ovf = 0;
  logic obs_done, obs_perr, obs_ferr, obs_ovf;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic       e_done;
    logic       e_perr;
    logic       e_ferr;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One bit period, entered and left at a falling edge. The model pops on
  // handshake, then a good final bit pushes if room remains, else overflows.
  task automatic tick(input logic b, input bit last, input logic [7:0] d, input bit p_err, input bit f_err);
    bit pop, e_done, e_ovf;
    check("VALID", valid, model_q.size() > 0);
    if (model_q.size() > 0) check("DATA", data, model_q[0]);
    rx  = b;
    pop = (model_q.size() > 0) && ready;
    @(posedge clk);
    if (pop) void'(model_q.pop_front());
    e_done = 0;
    e_ovf  = 0;
    if (last && !p_err && !f_err) begin
      if (model_q.size() < 4) begin
        model_q.push_back(d);
        e_done = 1;
      end else begin
        e_ovf = 1;
        model_ovf++;
      end
    end
    if (last && (p_err || f_err)) model_err++;
    @(negedge clk);
    obs_done = done;
    obs_perr = perr;
    obs_ferr = ferr;
    obs_ovf  = ovf;
    check("DONE", done, e_done);
    check("Rx_error", perr, last && p_err);
    check("FRAME_ERR", ferr, last && f_err);
    check("OVERFLOW", ovf, e_ovf);
  endtask

  // Odd parity: the data ones plus the parity bit must total an odd number.
  task automatic send(input logic [7:0] d, input logic par, input logic stop);
    bit pe, fe;
    pe = (((^d) ^ par) == 1'b0);
    fe = (stop == 1'b0);
    tick(1'b0, 0, d, 0, 0);
    for (int i = 0; i < 8; i++) tick(d[i], 0, d, 0, 0);
    tick(par, 0, d, 0, 0);
    tick(stop, 1, d, pe, fe);
  endtask

  task automatic tick12(input logic b);
    rx12 = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]  ovf_list [5];
    logic [7:0]  d;
    logic [11:0] v12;

    vecs[0] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ovf_list = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    rst = 1'b1; rx = 1'b1; ready = 1'b1; rx12 = 1'b1; ready12 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_DATA", data, 0);
    check("rst_VALID", valid, 0);
    check("rst_DONE", done, 0);
    check("rst_Rx_error", perr, 0);
    check("rst_FRAME_ERR", ferr, 0);
    check("rst_OVERFLOW", ovf, 0);
    rst = 1'b0;

    // Directed frames sent back-to-back with READY=1.
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].d, vecs[i].par, vecs[i].stop);
      check("tbl_DONE", obs_done, vecs[i].e_done);
      check("tbl_Rx_error", obs_perr, vecs[i].e_perr);
      check("tbl_FRAME_ERR", obs_ferr, vecs[i].e_ferr);
    end
    tick(1'b1, 0, 8'h00, 0, 0);

    // Fill with READY low; fifth good frame overflows, then drain.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(ovf_list[i], ~^ovf_list[i], 1'b1);
      check("fill_DONE", obs_done, i < 4);
      check("fill_OVERFLOW", obs_ovf, i == 4);
    end
    check("full_head", data, 8'h11);
    ready = 1'b1;
    repeat (5) tick(1'b1, 0, 8'h00, 0, 0);
    check("drained_VALID", valid, 0);

    // Reset mid-frame with two frames queued.
    ready = 1'b0;
    send(8'h66, ~^8'h66, 1'b1);
    send(8'h77, ~^8'h77, 1'b1);
    d = 8'h3C;
    tick(1'b0, 0, d, 0, 0);
    for (int i = 0; i < 4; i++) tick(d[i], 0, d, 0, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_DATA", data, 0);
    check("mid_rst_VALID", valid, 0);
    check("mid_rst_DONE", done, 0);
    check("mid_rst_Rx_error", perr, 0);
    check("mid_rst_FRAME_ERR", ferr, 0);
    check("mid_rst_OVERFLOW", ovf, 0);
    model_q.delete();
    model_err = 0;
    model_ovf = 0;
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    send(8'h3C, ~^8'h3C, 1'b1);
    check("post_rst_DONE", obs_done, 1);
    check("post_rst_DATA", data, 8'h3C);
    tick(1'b1, 0, 8'h00, 0, 0);

    // Random frames, occasional parity/stop errors and back-pressure.
    for (int n = 0; n < 150; n++) begin
      logic par, stop;
      ready = ($urandom_range(0, 3) != 0);
      d     = 8'($urandom);
      par   = (~^d) ^ ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 9) != 0);
      send(d, par, stop);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        ready = ($urandom_range(0, 1) != 0);
        tick(1'b1, 0, 8'h00, 0, 0);
      end
    end
    ready = 1'b1;
    repeat (6) tick(1'b1, 0, 8'h00, 0, 0);
`ifdef SERIAL_FRAME_RX_STATS_EN
    check("ERR_CNT", err_cnt, model_err);
    check("OVF_CNT", ovf_cnt, model_ovf);
`endif

    // Wide, even-parity, no-stop instance: 0xABC has seven ones.
    v12 = 12'hABC;
    tick12(1'b0);
    for (int i = 0; i < 12; i++) tick12(v12[i]);
    tick12(1'b1);
    check("w12_DONE", done12, 1);
    check("w12_Rx_error", perr12, 0);
    check("w12_VALID", valid12, 1);
    check("w12_DATA", data12, 12'hABC);
    tick12(1'b0);
    for (int i = 0; i < 12; i++) tick12(v12[i]);
    tick12(1'b0);
    check("w12_bad_Rx_error", perr12, 1);
    check("w12_bad_DONE", done12, 0);
    check("w12_bad_FRAME_ERR", ferr12, 0);
    check("w12_bad_VALID", valid12, 0);
    check("w12_OVERFLOW", ovf12, 0);
`ifdef SERIAL_FRAME_RX_STATS_EN
    check("w12_ERR_CNT", err_cnt12, 1);
    check("w12_OVF_CNT", ovf_cnt12, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
